// File: rtl/conv_12x12_engine.sv
// Streaming 3x3 convolution over a 12x12 signed 16-bit map; 10x10 valid-region results plus bias.
// Optional ReLU on the registered result when CONV12_RELU_EN is defined.
module conv_12x12_engine #(
  parameter logic signed [15:0] K00 = 16'sd0,
  parameter logic signed [15:0] K01 = 16'sd0,
  parameter logic signed [15:0] K02 = 16'sd0,
  parameter logic signed [15:0] K10 = 16'sd0,
  parameter logic signed [15:0] K11 = 16'sd1,
  parameter logic signed [15:0] K12 = 16'sd0,
  parameter logic signed [15:0] K20 = 16'sd0,
  parameter logic signed [15:0] K21 = 16'sd0,
  parameter logic signed [15:0] K22 = 16'sd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] input_port,
  input  logic signed [31:0] bias,
  input  logic               valid,
  output logic signed [31:0] output_port,
  output logic               finish,
  output logic               invalid
);

  localparam logic signed [15:0] KW [3][3] = '{'{K00, K01, K02},
                                               '{K10, K11, K12},
                                               '{K20, K21, K22}};

  logic        [3:0]  col, row;
  logic signed [15:0] lb0 [12];
  logic signed [15:0] lb1 [12];
  logic signed [15:0] win [3][3];
  logic signed [15:0] new_col [3];
  logic signed [31:0] acc, result;
  logic               win_done, frame_last;

  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [31:0] ea, eb;
    ea = 32'(a);
    eb = 32'(b);
    return ea * eb;
  endfunction

  // The sum uses the window as it will look after this edge's shift,
  // so the result registers on the same edge that accepts the pixel.
  always_comb begin
    new_col[0] = lb0[col];
    new_col[1] = lb1[col];
    new_col[2] = input_port;
    acc = bias;
    for (int unsigned r = 0; r < 3; r++) begin
      acc = acc + mul16(win[r][1], KW[r][0])
                + mul16(win[r][2], KW[r][1])
                + mul16(new_col[r], KW[r][2]);
    end
`ifdef CONV12_RELU_EN
    result = acc[31] ? '0 : acc;
`else
    result = acc;
`endif
    win_done   = (row >= 4'd2) && (col >= 4'd2);
    frame_last = (row == 4'd11) && (col == 4'd11);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col         <= '0;
      row         <= '0;
      output_port <= '0;
      invalid     <= 1'b1;
      finish      <= 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else begin
      invalid <= 1'b1;
      finish  <= 1'b0;
      if (valid) begin
        lb0[col] <= lb1[col];
        lb1[col] <= input_port;
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= new_col[r];
        end
        if (win_done) begin
          output_port <= result;
          invalid     <= 1'b0;
          finish      <= frame_last;
        end
        if (col == 4'd11) begin
          col <= '0;
          row <= (row == 4'd11) ? 4'd0 : row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_12x12_engine.sv
// Bench for conv_12x12_engine: four kernel variants share one stimulus stream and are
// compared every cycle against a frame-array reference model.
module tb_conv_12x12_engine;

  logic               clk;
  logic               reset;
  logic signed [15:0] input_port;
  logic signed [31:0] bias;
  logic               valid;
  logic        [31:0] op  [4];
  logic               fin [4];
  logic               inv [4];

  int checks;
  int errors;

  int                 kern [4][3][3];
  logic signed [15:0] fr [12][12];
  int                 mr, mc;
  int                 last [4];
  logic               exp_inv, exp_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: default identity kernel
  conv_12x12_engine dut_id (
    .clk(clk), .reset(reset), .input_port(input_port), .bias(bias), .valid(valid),
    .output_port(op[0]), .finish(fin[0]), .invalid(inv[0]));

  // 1: all ones
  conv_12x12_engine #(
    .K00(16'sd1), .K01(16'sd1), .K02(16'sd1),
    .K10(16'sd1), .K11(16'sd1), .K12(16'sd1),
    .K20(16'sd1), .K21(16'sd1), .K22(16'sd1)
  ) dut_ones (
    .clk(clk), .reset(reset), .input_port(input_port), .bias(bias), .valid(valid),
    .output_port(op[1]), .finish(fin[1]), .invalid(inv[1]));

  // 2: negated centre tap
  conv_12x12_engine #(
    .K11(-16'sd1)
  ) dut_neg (
    .clk(clk), .reset(reset), .input_port(input_port), .bias(bias), .valid(valid),
    .output_port(op[2]), .finish(fin[2]), .invalid(inv[2]));

  // 3: asymmetric, extreme weights to expose tap placement and 32-bit wrap
  conv_12x12_engine #(
    .K00(16'sd32767), .K01(-16'sd2),    .K02(16'sd5),
    .K10(-16'sd7),    .K11(16'sd11),    .K12(-16'sd32768),
    .K20(16'sd3),     .K21(16'sd1000),  .K22(-16'sd1)
  ) dut_mix (
    .clk(clk), .reset(reset), .input_port(input_port), .bias(bias), .valid(valid),
    .output_port(op[3]), .finish(fin[3]), .invalid(inv[3]));

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic int model(input int d, input int r, input int c, input int b);
    int s;
    s = b;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(fr[r-2+i][c-2+j]) * kern[d][i][j];
`ifdef CONV12_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic check_all(input string phase);
    for (int d = 0; d < 4; d++) begin
      chk32($sformatf("%s_out%0d", phase, d), op[d], last[d]);
      chk1($sformatf("%s_inv%0d", phase, d), inv[d], exp_inv);
      chk1($sformatf("%s_fin%0d", phase, d), fin[d], exp_fin);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] px, input logic [31:0] b);
    int bb;
    valid      = v;
    input_port = px;
    bias       = b;
    bb         = b;
    exp_inv    = 1'b1;
    exp_fin    = 1'b0;
    if (v) begin
      fr[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        exp_inv = 1'b0;
        exp_fin = (mr == 11 && mc == 11);
        for (int d = 0; d < 4; d++) last[d] = model(d, mr, mc, bb);
      end
      mc++;
      if (mc == 12) begin
        mc = 0;
        mr = (mr == 11) ? 0 : mr + 1;
      end
    end
    @(posedge clk);
    #1;
    check_all("run");
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    mr = 0;
    mc = 0;
    for (int d = 0; d < 4; d++) last[d] = 0;
    exp_inv = 1'b1;
    exp_fin = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      valid      = 1'b1;
      input_port = 16'($urandom);
      bias       = $urandom;
      @(posedge clk);
      #1;
      check_all("rst");
    end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    valid = 1'b0;
    input_port = '0;
    bias = '0;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) kern[d][i][j] = 0;
    kern[0][1][1] = 1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) kern[1][i][j] = 1;
    kern[2][1][1] = -1;
    kern[3][0][0] = 32767; kern[3][0][1] = -2;   kern[3][0][2] = 5;
    kern[3][1][0] = -7;    kern[3][1][1] = 11;   kern[3][1][2] = -32768;
    kern[3][2][0] = 3;     kern[3][2][1] = 1000; kern[3][2][2] = -1;

    #2;
    do_reset(3);

    // Identity ramp, continuous
    for (int i = 0; i < 144; i++) begin
      step(1'b1, 16'(i), 32'h0);
      if (i == 25) chk1("pre_first_inv", inv[0], 1'b1);
      if (i == 26) chk32("first_id", op[0], 32'd13);
      if (i == 143) chk32("last_id", op[0], 32'd130);
    end

    // Ones frame back-to-back; bias drops to 0 mid-frame
    for (int i = 0; i < 144; i++) begin
      step(1'b1, 16'd1, (i < 80) ? 32'h10 : 32'h0);
      if (i == 26) chk32("ones_b16", op[1], 32'h19);
      if (i == 100) chk32("ones_b0", op[1], 32'h9);
    end

    // Identity ramp with 5-cycle gaps every 7 pixels
    for (int i = 0; i < 144; i++) begin
      step(1'b1, 16'(i), 32'h0);
      if (i % 7 == 6)
        for (int g = 0; g < 5; g++) step(1'b0, 16'($urandom), $urandom);
    end

    // Mid-frame reset, then a random frame
    for (int i = 0; i < 60; i++) step(1'b1, 16'($urandom), $urandom);
    do_reset(2);
    for (int i = 0; i < 144; i++) step(1'b1, 16'($urandom), $urandom);

    // Constant 13 through negated centre tap
    for (int i = 0; i < 144; i++) step(1'b1, 16'd13, 32'h0);
`ifdef CONV12_RELU_EN
    chk32("neg13", op[2], 32'h0);
`else
    chk32("neg13", op[2], 32'hFFFF_FFF3);
`endif

    // Random frame with random idle gaps and random bias
    for (int i = 0; i < 144; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        step(1'b0, 16'($urandom), $urandom);
      step(1'b1, 16'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_12x12_engine.md
# conv_12x12_engine

Streaming 3x3 2-D convolution engine for one 12x12 feature map of signed 16-bit pixels. It sits between a pixel source, such as a previous layer's output stream, and a result sink. It accepts one raster-order pixel per enabled clock and emits the 10x10 valid-region convolution results, with bias added, as signed 32-bit words. Kernel weights are fixed at elaboration; the bias is a live input.

## Interface
- K00..K22, default 0 except K11 = 1: signed 16-bit kernel weights. Krc multiplies window row r, column c; row 0 is the oldest row and column 0 the leftmost.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- input_port  input  16  signed pixel, raster order (row-major, row 0 first).
- bias  input  32  signed bias added to every result; sampled on the edge that produces each result.
- valid  input  1  high = input_port carries a pixel that is consumed on this rising edge.
- output_port  output  32  signed convolution result, registered.
- finish  output  1  one-cycle pulse coincident with the 100th (last) result of a frame.
- invalid  output  1  high = output_port does not carry a new result this cycle; low for exactly one cycle per result.

## Operation
- Column counter col (0..11) and row counter row (0..11) index the next incoming pixel. Both advance only when valid=1: col wraps 11→0 and increments row; row wraps 11→0 at the end of a frame.
- Two 12-entry line buffers hold the previous two rows. A 3x3 window register shifts left by one column on each accepted pixel.
- Window completion: an accepted pixel at (row≥2, col≥2) completes the window with top-left corner (row-2, col-2). The result for that window is registered on the same edge.
- Result = sum over r,c of (window[r][c] × Krc) + bias.
  - Each product is a signed 16×16 → 32-bit multiply.
  - The sum uses 32-bit two's-complement arithmetic that wraps on overflow; there is no saturation.
- Results appear in raster order: 10 per row, 100 per frame.
- End of frame: finish pulses with result 100, when pixel (11,11) is accepted. The counters wrap, so the next accepted pixel is (0,0) of a new frame. No idle gap is required between frames.
- Holding state:
  - With valid=0, counters, line buffers and window hold.
  - invalid=1.
  - output_port holds its last value.
- Accepted pixel that does not complete a window: invalid=1, output_port holds.

## Timing
- Reset values (reset=0, asynchronous): output_port=0, invalid=1, finish=0. Counters, line buffers and window clear to 0.
- Reset mid-frame: the frame is discarded. The first accepted pixel after release is (0,0).
- Latency: one cycle. The result is visible after the edge that accepts the completing pixel; invalid=0 and finish are valid in that same cycle.
- Throughput: one pixel per clock; no back-pressure. Gaps in valid are allowed anywhere.
- bias may change between results. Each result uses the bias present at its producing edge.

## Configuration
- CONV12_RELU_EN defined: a negative 32-bit result is replaced by 0 before registering (ReLU). invalid and finish timing are unchanged.
- CONV12_RELU_EN undefined: the raw signed result is output.

## Test plan
- Reset: hold reset=0 for 3 cycles with valid=1 → output_port=0, invalid=1, finish=0 throughout. After release, the first pixel is (0,0).
- Default (identity) kernel, pixel(r,c)=12r+c, bias=0, valid=1 continuously:
  - First invalid=0 appears in the cycle after pixel 26 is accepted, with output_port=13.
  - The full sequence is 13..22, 25..34, …, 121..130.
  - finish pulses only with 130.
- All weights 1, all pixels 1, bias=0x10 → every one of the 100 results = 0x19. The bias changed to 0 mid-frame takes effect on the next result (=9).
- valid gaps of 5 cycles inserted every 7 pixels, identity kernel → the same 100-value sequence as the continuous case. invalid stays 1 during gaps; output_port never changes while invalid=1.
- Reset asserted after 60 pixels, then a full frame → 100 correct results. No stale result precedes them.
- K11=-1, pixels 13, bias=0:
  - Without CONV12_RELU_EN: output_port=0xFFFFFFF3.
  - With CONV12_RELU_EN: output_port=0.
